// File: rtl/gshare_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : gshare_branch_predictor
// Description : Gshare direction predictor (GHR xor PC indexing a table of
//               2-bit counters) with a direct-mapped BTB. Lookup happens in
//               fetch and is registered into decode. Training and GHR repair
//               come from resolved branches in execute. Two saturating
//               performance counters track resolved and mispredicted branches.
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_branch_predictor #(
  parameter int PC_W      = 5,
  parameter int GHR_W     = 4,
  parameter int BTB_IDX_W = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  // fetch side
  input  logic                 f_valid,
  input  logic [PC_W-1:0]      f_pc,
  input  logic                 f_stall,
  input  logic                 f_flush,
  // decode side (registered prediction)
  output logic                 d_valid,
  output logic                 d_pred_taken,
  output logic                 d_hit,
  output logic [PC_W-1:0]      d_target,
  output logic [GHR_W-1:0]     d_ghr,
  output logic [GHR_W-1:0]     d_pht_idx,
  // execute side (resolution / training)
  input  logic                 e_upd_valid,
  input  logic [PC_W-1:0]      e_pc,
  input  logic [GHR_W-1:0]     e_pht_idx,
  input  logic [GHR_W-1:0]     e_ghr,
  input  logic                 e_taken,
  input  logic [PC_W-1:0]      e_target,
  input  logic                 e_mispredict,
  // performance counters
  output logic [CNT_W-1:0]     br_count,
  output logic [CNT_W-1:0]     mispred_count
);

  localparam int c_PHT_N = 1 << GHR_W;
  localparam int c_BTB_N = 1 << BTB_IDX_W;
  localparam int c_TAG_W = PC_W - BTB_IDX_W;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [GHR_W-1:0]   r_ghr;
  logic [1:0]         r_pht        [c_PHT_N];
  logic [c_BTB_N-1:0] r_btb_valid;
  logic [c_TAG_W-1:0] r_btb_tag    [c_BTB_N];
  logic [PC_W-1:0]    r_btb_target [c_BTB_N];

  // --------------------------------------------------------------------------
  // Fetch-side lookup wires
  // --------------------------------------------------------------------------
  logic [GHR_W-1:0]     w_pc_low;
  logic [GHR_W-1:0]     w_idx;
  logic [BTB_IDX_W-1:0] w_entry;
  logic [c_TAG_W-1:0]   w_tag;
  logic                 w_hit;
  logic                 w_pred_taken;
  logic [PC_W-1:0]      w_target;
  logic                 w_fetch_adv;

  // Execute-side training wires
  logic [BTB_IDX_W-1:0] w_e_entry;
  logic [c_TAG_W-1:0]   w_e_tag;
  logic [1:0]           w_pht_cur;
  logic [1:0]           w_pht_next;
  logic                 w_repair;
  logic [GHR_W-1:0]     w_ghr_next;

  // Oldest bit of the carried GHR falls off the end during repair.
  logic                 w_unused_ghr_msb;
  assign w_unused_ghr_msb = e_ghr[GHR_W-1];

  // The PC is zero-extended when it is narrower than the history.
  if (PC_W >= GHR_W) begin : g_pc_trunc
    assign w_pc_low = f_pc[GHR_W-1:0];
  end else begin : g_pc_zext
    assign w_pc_low = {{(GHR_W-PC_W){1'b0}}, f_pc};
  end

  assign w_idx        = w_pc_low ^ r_ghr;
  assign w_entry      = f_pc[BTB_IDX_W-1:0];
  assign w_tag        = f_pc[PC_W-1:BTB_IDX_W];
  assign w_hit        = r_btb_valid[w_entry] && (r_btb_tag[w_entry] == w_tag);
  assign w_pred_taken = w_hit && r_pht[w_idx][1];
  assign w_target     = w_hit ? r_btb_target[w_entry] : '0;

  // A fetch only advances the pipeline (and the history) when not held/flushed.
  assign w_fetch_adv  = f_valid && !f_stall && !f_flush;

  assign w_e_entry    = e_pc[BTB_IDX_W-1:0];
  assign w_e_tag      = e_pc[PC_W-1:BTB_IDX_W];
  assign w_repair     = e_upd_valid && e_mispredict;

  // Saturating 2-bit counter step for the resolved branch's PHT entry.
  always_comb begin
    w_pht_cur  = r_pht[e_pht_idx];
    w_pht_next = w_pht_cur;
    if (e_taken) begin
      if (w_pht_cur != 2'b11) begin
        w_pht_next = w_pht_cur + 2'b01;
      end
    end else begin
      if (w_pht_cur != 2'b00) begin
        w_pht_next = w_pht_cur - 2'b01;
      end
    end
  end

  // History update: a mispredict repair wins over the speculative fetch shift.
  always_comb begin
    w_ghr_next = r_ghr;
    if (w_repair) begin
      w_ghr_next = {e_ghr[GHR_W-2:0], e_taken};
    end else if (w_fetch_adv && w_hit) begin
      w_ghr_next = {r_ghr[GHR_W-2:0], w_pred_taken};
    end
  end

  // Global history register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ghr <= '0;
    end else begin
      r_ghr <= w_ghr_next;
    end
  end

  // Pattern history table: trained by every resolved branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_PHT_N; i++) begin
        r_pht[i] <= 2'b01;
      end
    end else if (e_upd_valid) begin
      r_pht[e_pht_idx] <= w_pht_next;
    end
  end

  // BTB valid bits: only taken branches allocate, overwriting any alias.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btb_valid <= '0;
    end else if (e_upd_valid && e_taken) begin
      r_btb_valid[w_e_entry] <= 1'b1;
    end
  end

  // BTB tag/target payload; qualified by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    if (e_upd_valid && e_taken) begin
      r_btb_tag[w_e_entry]    <= w_e_tag;
      r_btb_target[w_e_entry] <= e_target;
    end
  end

  // F/D prediction register: flush beats stall beats load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_valid      <= 1'b0;
      d_pred_taken <= 1'b0;
      d_hit        <= 1'b0;
      d_target     <= '0;
      d_ghr        <= '0;
      d_pht_idx    <= '0;
    end else if (f_flush) begin
      d_valid      <= 1'b0;
      d_pred_taken <= 1'b0;
      d_hit        <= 1'b0;
      d_target     <= '0;
      d_ghr        <= '0;
      d_pht_idx    <= '0;
    end else if (!f_stall) begin
      d_valid      <= f_valid;
      d_pred_taken <= w_pred_taken;
      d_hit        <= w_hit;
      d_target     <= w_target;
      d_ghr        <= r_ghr;
      d_pht_idx    <= w_idx;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (e_upd_valid && (br_count != '1)) begin
        br_count <= br_count + 1'b1;
      end
      if (w_repair && (mispred_count != '1)) begin
        mispred_count <= mispred_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gshare_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_gshare_branch_predictor
// Description : Directed self-checking bench for gshare_branch_predictor,
//               built with 3-bit performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gshare_branch_predictor;

  localparam int PC_W      = 5;
  localparam int GHR_W     = 4;
  localparam int BTB_IDX_W = 3;
  localparam int CNT_W     = 3;

  logic             clk;
  logic             reset;
  logic             f_valid;
  logic [PC_W-1:0]  f_pc;
  logic             f_stall;
  logic             f_flush;
  logic             d_valid;
  logic             d_pred_taken;
  logic             d_hit;
  logic [PC_W-1:0]  d_target;
  logic [GHR_W-1:0] d_ghr;
  logic [GHR_W-1:0] d_pht_idx;
  logic             e_upd_valid;
  logic [PC_W-1:0]  e_pc;
  logic [GHR_W-1:0] e_pht_idx;
  logic [GHR_W-1:0] e_ghr;
  logic             e_taken;
  logic [PC_W-1:0]  e_target;
  logic             e_mispredict;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  int checks;
  int errors;

  gshare_branch_predictor #(
    .PC_W      (PC_W),
    .GHR_W     (GHR_W),
    .BTB_IDX_W (BTB_IDX_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .f_valid       (f_valid),
    .f_pc          (f_pc),
    .f_stall       (f_stall),
    .f_flush       (f_flush),
    .d_valid       (d_valid),
    .d_pred_taken  (d_pred_taken),
    .d_hit         (d_hit),
    .d_target      (d_target),
    .d_ghr         (d_ghr),
    .d_pht_idx     (d_pht_idx),
    .e_upd_valid   (e_upd_valid),
    .e_pc          (e_pc),
    .e_pht_idx     (e_pht_idx),
    .e_ghr         (e_ghr),
    .e_taken       (e_taken),
    .e_target      (e_target),
    .e_mispredict  (e_mispredict),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input int v, input int hit, input int pt,
                       input int tgt, input int ghr, input int idx);
    chk({tag, ".d_valid"},      {31'd0, d_valid},      v);
    chk({tag, ".d_hit"},        {31'd0, d_hit},        hit);
    chk({tag, ".d_pred_taken"}, {31'd0, d_pred_taken}, pt);
    chk({tag, ".d_target"},     {27'd0, d_target},     tgt);
    chk({tag, ".d_ghr"},        {28'd0, d_ghr},        ghr);
    chk({tag, ".d_pht_idx"},    {28'd0, d_pht_idx},    idx);
  endtask

  task automatic chk_cnt(input string tag, input int br, input int mp);
    chk({tag, ".br_count"},      {29'd0, br_count},      br);
    chk({tag, ".mispred_count"}, {29'd0, mispred_count}, mp);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Unknown inputs, then asynchronous reset before any clock edge.
    reset        = 1'b1;
    f_valid      = 1'bx;
    f_pc         = 'x;
    f_stall      = 1'bx;
    f_flush      = 1'bx;
    e_upd_valid  = 1'bx;
    e_pc         = 'x;
    e_pht_idx    = 'x;
    e_ghr        = 'x;
    e_taken      = 1'bx;
    e_target     = 'x;
    e_mispredict = 1'bx;
    #2 reset = 1'b0;
    #1;
    chk_d("reset", 0, 0, 0, 0, 0, 0);
    chk_cnt("reset", 0, 0);

    f_valid = 0; f_pc = 0; f_stall = 0; f_flush = 0;
    e_upd_valid = 0; e_pc = 0; e_pht_idx = 0; e_ghr = 0;
    e_taken = 0; e_target = 0; e_mispredict = 0;
    tick();
    tick();
    reset = 1'b1;

    // Cold lookup: BTB empty, GHR=0 -> idx=5, miss.
    f_valid = 1; f_pc = 5;
    tick();
    chk_d("cold_lookup", 1, 0, 0, 0, 0, 5);

    // Cold train pc=5 -> 12 twice (PHT[5] 1->3, GHR repaired to 0001).
    f_valid = 0; f_pc = 0;
    e_upd_valid = 1; e_pc = 5; e_pht_idx = 5; e_ghr = 0;
    e_taken = 1; e_target = 12; e_mispredict = 1;
    tick();
    tick();
    chk_cnt("cold_train", 2, 2);

    // Repair GHR back to 0 (sacrifices PHT[0]).
    e_pc = 0; e_pht_idx = 0; e_ghr = 4'b1000; e_taken = 0; e_mispredict = 1;
    tick();
    chk_cnt("repair_to_zero", 3, 3);

    // Fetch pc=5 with GHR=0: idx 5, strongly taken.
    e_upd_valid = 0; e_mispredict = 0;
    f_valid = 1; f_pc = 5;
    tick();
    chk_d("trained_hit", 1, 1, 1, 12, 0, 5);
    // GHR shifted to 0001: idx 4, weakly not-taken.
    tick();
    chk_d("ghr_shift", 1, 1, 0, 12, 1, 4);

    // Four taken updates on PHT idx 2 (BTB pc=3 -> 7); last one repairs GHR to 0001.
    f_valid = 0;
    e_upd_valid = 1; e_pc = 3; e_target = 7; e_pht_idx = 2;
    e_taken = 1; e_mispredict = 0; e_ghr = 0;
    tick();
    tick();
    tick();
    e_mispredict = 1; e_ghr = 4'b1000;
    tick();
    chk_cnt("pht_taken_train", 7, 4);

    e_upd_valid = 0; e_mispredict = 0;
    f_valid = 1; f_pc = 3;
    tick();
    chk_d("pht_sat_hi", 1, 1, 1, 7, 1, 2);

    // Four not-taken updates on idx 2: 3->2->1->0->0.
    f_valid = 0;
    e_upd_valid = 1; e_taken = 0; e_pht_idx = 2; e_pc = 3; e_mispredict = 0;
    tick();
    tick();
    tick();
    tick();
    // Repair GHR to 0001 using PHT[15] as the victim.
    e_pht_idx = 15; e_ghr = 0; e_taken = 1; e_mispredict = 1; e_pc = 3; e_target = 7;
    tick();

    e_upd_valid = 0; e_mispredict = 0;
    f_valid = 1; f_pc = 3;
    tick();
    chk_d("pht_sat_lo", 1, 1, 0, 7, 1, 2);

    // GHR=0010. Repair to 1101 in the same cycle as a fetch BTB hit.
    f_pc = 3;
    e_upd_valid = 1; e_mispredict = 1; e_ghr = 4'b0110; e_taken = 1;
    e_pht_idx = 15; e_pc = 6; e_target = 9;
    tick();
    chk_d("repair_fetch", 1, 1, 0, 7, 2, 1);

    e_upd_valid = 0; e_mispredict = 0;
    f_pc = 5;
    tick();
    chk_d("repair_ghr", 1, 1, 0, 12, 4'hD, 8);

    // Stall: D and GHR (1010) hold.
    f_stall = 1; f_pc = 3;
    tick();
    chk_d("stall1", 1, 1, 0, 12, 4'hD, 8);
    tick();
    chk_d("stall2", 1, 1, 0, 12, 4'hD, 8);
    tick();
    chk_d("stall3", 1, 1, 0, 12, 4'hD, 8);

    f_stall = 0; f_pc = 6;
    tick();
    chk_d("post_stall", 1, 1, 0, 9, 4'hA, 12);

    // Flush with stall clears D; GHR (0100) does not shift.
    f_stall = 1; f_flush = 1; f_pc = 3;
    tick();
    chk_d("flush", 0, 0, 0, 0, 0, 0);

    f_stall = 0; f_flush = 0; f_pc = 3;
    tick();
    chk_d("post_flush", 1, 1, 0, 7, 4, 7);

    // Mispredict without update valid is ignored (GHR stays 1000).
    f_valid = 0; f_pc = 0;
    e_upd_valid = 0; e_mispredict = 1; e_ghr = 4'hF; e_taken = 1;
    tick();
    chk_cnt("ignored_mp", 7, 6);

    e_mispredict = 0;
    f_valid = 1; f_pc = 0;
    tick();
    chk_d("ignored_mp", 1, 0, 0, 0, 8, 8);

    // Reset mid-operation clears everything immediately.
    f_pc = 5;
    reset = 1'b0;
    #1;
    chk_d("mid_reset", 0, 0, 0, 0, 0, 0);
    chk_cnt("mid_reset", 0, 0);
    tick();
    reset = 1'b1;

    f_valid = 1; f_pc = 5;
    tick();
    chk_d("post_reset", 1, 0, 0, 0, 0, 5);

    // Counter saturation: 9 mispredicting updates on 3-bit counters.
    f_valid = 0; f_pc = 0;
    e_upd_valid = 1; e_mispredict = 1; e_taken = 0;
    e_pht_idx = 0; e_pc = 0; e_ghr = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 1) chk_cnt("cnt_1", 1, 1);
      if (i == 7) chk_cnt("cnt_7", 7, 7);
    end
    chk_cnt("cnt_sat", 7, 7);
    e_upd_valid = 0; e_mispredict = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
